// File: rtl/ipd_inst_queue_pkg.sv
// Shared pre-decode definitions: inst-type bit indices, opcode fields, decoded/queued record layouts.
// Latency: n/a (types only); backpressure: n/a.
package ipd_inst_queue_pkg;

    localparam int INST_TYPE_WD     = 27;
    localparam int IPD_TO_ID_BUS_WD = INST_TYPE_WD + 111;

    localparam int IT_ADD_W     = 0;
    localparam int IT_SUB_W     = 1;
    localparam int IT_SLT       = 2;
    localparam int IT_SLTU      = 3;
    localparam int IT_NOR       = 4;
    localparam int IT_AND       = 5;
    localparam int IT_OR        = 6;
    localparam int IT_XOR       = 7;
    localparam int IT_MUL_W     = 8;
    localparam int IT_SLLI_W    = 9;
    localparam int IT_SRLI_W    = 10;
    localparam int IT_SRAI_W    = 11;
    localparam int IT_ADDI_W    = 12;
    localparam int IT_ORI       = 13;
    localparam int IT_ANDI      = 14;
    localparam int IT_LU12I_W   = 15;
    localparam int IT_PCADDU12I = 16;
    localparam int IT_JIRL      = 17;
    localparam int IT_B         = 18;
    localparam int IT_BL        = 19;
    localparam int IT_BEQ       = 20;
    localparam int IT_BNE       = 21;
    localparam int IT_LD_W      = 22;
    localparam int IT_ST_W      = 23;
    localparam int IT_ST_B      = 24;
    localparam int IT_LD_B      = 25;
    localparam int IT_INE       = 26;

    // opcode fields: inst[31:15], inst[31:22], inst[31:25], inst[31:26]
    localparam logic [16:0] OP17_ADD_W  = 17'h00020;
    localparam logic [16:0] OP17_SUB_W  = 17'h00022;
    localparam logic [16:0] OP17_SLT    = 17'h00024;
    localparam logic [16:0] OP17_SLTU   = 17'h00025;
    localparam logic [16:0] OP17_NOR    = 17'h00028;
    localparam logic [16:0] OP17_AND    = 17'h00029;
    localparam logic [16:0] OP17_OR     = 17'h0002A;
    localparam logic [16:0] OP17_XOR    = 17'h0002B;
    localparam logic [16:0] OP17_MUL_W  = 17'h00038;
    localparam logic [16:0] OP17_SLLI_W = 17'h00081;
    localparam logic [16:0] OP17_SRLI_W = 17'h00089;
    localparam logic [16:0] OP17_SRAI_W = 17'h00091;
    localparam logic [9:0]  OP10_ADDI_W = 10'h00A;
    localparam logic [9:0]  OP10_ORI    = 10'h00E;
    localparam logic [9:0]  OP10_ANDI   = 10'h00D;
    localparam logic [9:0]  OP10_LD_W   = 10'h0A2;
    localparam logic [9:0]  OP10_LD_B   = 10'h0A0;
    localparam logic [9:0]  OP10_ST_W   = 10'h0A6;
    localparam logic [9:0]  OP10_ST_B   = 10'h0A4;
    localparam logic [6:0]  OP7_LU12I_W = 7'h0A;
    localparam logic [6:0]  OP7_PCADDU  = 7'h0E;
    localparam logic [5:0]  OP6_JIRL    = 6'h13;
    localparam logic [5:0]  OP6_B       = 6'h14;
    localparam logic [5:0]  OP6_BL      = 6'h15;
    localparam logic [5:0]  OP6_BEQ     = 6'h16;
    localparam logic [5:0]  OP6_BNE     = 6'h17;

    typedef struct packed {
        logic [INST_TYPE_WD-1:0] inst_type;
        logic [31:0]             imm;
        logic [4:0]              waddr;
        logic [4:0]              raddr2;
        logic [4:0]              raddr1;
    } pd_t;

    typedef struct packed {
        logic [INST_TYPE_WD-1:0] inst_type;
        logic [31:0]             pred_pc;
        logic [31:0]             inst_pc;
        logic [31:0]             imm;
        logic [4:0]              waddr;
        logic [4:0]              raddr2;
        logic [4:0]              raddr1;
    } rec_t;

    function automatic rec_t pack_rec(pd_t pd, logic [31:0] pc, logic [31:0] pred_pc);
        rec_t r;
        r.inst_type = pd.inst_type;
        r.pred_pc   = pred_pc;
        r.inst_pc   = pc;
        r.imm       = pd.imm;
        r.waddr     = pd.waddr;
        r.raddr2    = pd.raddr2;
        r.raddr1    = pd.raddr1;
        return r;
    endfunction

endpackage

// File: rtl/ipd_inst_queue_if.sv
// IF->IPD->ID handshake bundle; slave modport is the queue, master modport is its environment.
// Latency/backpressure: defined by the queue (in_ready / out_ready).
interface ipd_inst_queue_if #(parameter int PTR_W = 2);
    import ipd_inst_queue_pkg::*;

    logic           in_valid;
    logic [31:0]    in_pc;
    logic [31:0]    in_pred_pc;
    logic [31:0]    inst_ram_r_data;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    rec_t           out_bus;
    logic           flush;
    logic [PTR_W:0] occupancy;

    modport slave (
        input  in_valid, in_pc, in_pred_pc, inst_ram_r_data, out_ready, flush,
        output in_ready, out_valid, out_bus, occupancy
    );

    modport master (
        output in_valid, in_pc, in_pred_pc, inst_ram_r_data, out_ready, flush,
        input  in_ready, out_valid, out_bus, occupancy
    );
endinterface

// File: rtl/ipd_inst_queue_predecoder.sv
// Combinational pre-decoder: inst word -> one-hot type, imm, waddr, raddr2, raddr1.
// Latency 0; no backpressure (pure function of inst_i).
module ipd_inst_queue_predecoder
    import ipd_inst_queue_pkg::*;
(
    input  logic [31:0] inst_i,
    output pd_t         pd_o
);
    logic [INST_TYPE_WD-1:0] t;
    logic [4:0] rd, rj, rk;
    logic is_3r, is_shift, is_si12, is_ui12, is_si20, is_off16, is_off26, is_rj, is_rd2, no_wb;

    assign rd = inst_i[4:0];
    assign rj = inst_i[9:5];
    assign rk = inst_i[14:10];

    always_comb begin
        t = '0;
        t[IT_ADD_W]     = inst_i[31:15] == OP17_ADD_W;
        t[IT_SUB_W]     = inst_i[31:15] == OP17_SUB_W;
        t[IT_SLT]       = inst_i[31:15] == OP17_SLT;
        t[IT_SLTU]      = inst_i[31:15] == OP17_SLTU;
        t[IT_NOR]       = inst_i[31:15] == OP17_NOR;
        t[IT_AND]       = inst_i[31:15] == OP17_AND;
        t[IT_OR]        = inst_i[31:15] == OP17_OR;
        t[IT_XOR]       = inst_i[31:15] == OP17_XOR;
        t[IT_MUL_W]     = inst_i[31:15] == OP17_MUL_W;
        t[IT_SLLI_W]    = inst_i[31:15] == OP17_SLLI_W;
        t[IT_SRLI_W]    = inst_i[31:15] == OP17_SRLI_W;
        t[IT_SRAI_W]    = inst_i[31:15] == OP17_SRAI_W;
        t[IT_ADDI_W]    = inst_i[31:22] == OP10_ADDI_W;
        t[IT_ORI]       = inst_i[31:22] == OP10_ORI;
        t[IT_ANDI]      = inst_i[31:22] == OP10_ANDI;
        t[IT_LD_W]      = inst_i[31:22] == OP10_LD_W;
        t[IT_LD_B]      = inst_i[31:22] == OP10_LD_B;
        t[IT_ST_W]      = inst_i[31:22] == OP10_ST_W;
        t[IT_ST_B]      = inst_i[31:22] == OP10_ST_B;
        t[IT_LU12I_W]   = inst_i[31:25] == OP7_LU12I_W;
        t[IT_PCADDU12I] = inst_i[31:25] == OP7_PCADDU;
        t[IT_JIRL]      = inst_i[31:26] == OP6_JIRL;
        t[IT_B]         = inst_i[31:26] == OP6_B;
        t[IT_BL]        = inst_i[31:26] == OP6_BL;
        t[IT_BEQ]       = inst_i[31:26] == OP6_BEQ;
        t[IT_BNE]       = inst_i[31:26] == OP6_BNE;
        t[IT_INE]       = ~|t[IT_INE-1:0];
    end

    assign is_3r    = |t[IT_MUL_W:IT_ADD_W];
    assign is_shift = |t[IT_SRAI_W:IT_SLLI_W];
    assign is_si12  = t[IT_ADDI_W] | t[IT_LD_W] | t[IT_LD_B] | t[IT_ST_W] | t[IT_ST_B];
    assign is_ui12  = t[IT_ORI] | t[IT_ANDI];
    assign is_si20  = t[IT_LU12I_W] | t[IT_PCADDU12I];
    assign is_off16 = t[IT_JIRL] | t[IT_BEQ] | t[IT_BNE];
    assign is_off26 = t[IT_B] | t[IT_BL];
    assign is_rj    = is_shift | is_si12 | is_ui12 | is_off16;
    assign is_rd2   = t[IT_BEQ] | t[IT_BNE] | t[IT_ST_W] | t[IT_ST_B];
    // b/bl carry no register write in this encoding of the bus, same as branches/stores
    assign no_wb    = is_off26 | is_rd2 | t[IT_INE];

    always_comb begin
        pd_o           = '0;
        pd_o.inst_type = t;
        if (is_3r) begin
            pd_o.raddr1 = rk;
            pd_o.raddr2 = rj;
        end else if (is_rj) begin
            pd_o.raddr1 = rj;
        end
        if (is_rd2) pd_o.raddr2 = rd;
        if (!no_wb) pd_o.waddr = rd;
        if (is_si12)       pd_o.imm = {{20{inst_i[21]}}, inst_i[21:10]};
        else if (is_ui12)  pd_o.imm = {20'd0, inst_i[21:10]};
        else if (is_shift) pd_o.imm = {27'd0, inst_i[14:10]};
        else if (is_si20)  pd_o.imm = {inst_i[24:5], 12'd0};
        else if (is_off16) pd_o.imm = {{14{inst_i[25]}}, inst_i[25:10], 2'b00};
        else if (is_off26) pd_o.imm = {{4{inst_i[9]}}, inst_i[9:0], inst_i[25:10], 2'b00};
    end
endmodule

// File: rtl/ipd_inst_queue.sv
// Pre-decode stage: decodes fetched insts into a DEPTH-entry queue feeding ID; optional IPD_QUEUE_BYPASS_EN.
// Latency 1 (0 on empty with IPD_QUEUE_BYPASS_EN); backpressure: in_ready drops when full or flushed.
module ipd_inst_queue
    import ipd_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic             clk,
    input  logic             reset,
    ipd_inst_queue_if.slave  q_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    rec_t           mem_q [DEPTH];
    pd_t            pd;
    rec_t           in_rec;
    logic           kill, full, empty, push, pop, bypass;

    ipd_inst_queue_predecoder u_predecoder (
        .inst_i (q_if.inst_ram_r_data),
        .pd_o   (pd)
    );

    assign in_rec = pack_rec(pd, q_if.in_pc, q_if.in_pred_pc);

    // reset in the middle of traffic looks exactly like a flush to both neighbours
    assign kill  = q_if.flush | reset;
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) & (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

`ifdef IPD_QUEUE_BYPASS_EN
    assign bypass = empty & q_if.in_valid & q_if.out_ready & ~kill;
`else
    assign bypass = 1'b0;
`endif

    assign q_if.in_ready  = ~full & ~kill;
    assign q_if.out_valid = (~empty & ~kill) | bypass;
    assign q_if.out_bus   = bypass ? in_rec : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign q_if.occupancy = wr_ptr_q - rd_ptr_q;

    assign push = q_if.in_valid & q_if.in_ready & ~bypass;
    assign pop  = ~empty & ~kill & q_if.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= in_rec;
    end
endmodule
